// File: rtl/gray_ptr_sync.sv
// Multi-stage synchroniser for a Gray-coded FIFO pointer, with registered
// Gray-to-binary conversion, per-cycle advance reporting and jump detection.
module gray_ptr_sync #(
  parameter int ADDR_WIDTH = 4,
  parameter int STAGES     = 2
) (
  input  logic                  dst_clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH:0]   ptr_gray,
  input  logic                  err_clr,
  output logic [ADDR_WIDTH:0]   ptr_gray_sync,
  output logic [ADDR_WIDTH:0]   ptr_bin_sync,
  output logic [ADDR_WIDTH:0]   ptr_delta,
  output logic                  ptr_upd,
  output logic                  err_jump,
  output logic                  sync_valid
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DEPTH      = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [2:0]          FLUSH_LAST = 3'(STAGES + 1);

  generate
    if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
      $error("gray_ptr_sync: STAGES must be in 2..4");
    end
  endgenerate

  logic [PW-1:0] stage [STAGES];
  logic [PW-1:0] bin_next;
  logic [PW-1:0] delta_next;
  logic [2:0]    flush_cnt;

  // NOTE: the synchroniser chain is a handful of flops, not a RAM, so every
  // stage takes the reset; all sequential state uses non-blocking assignment
  // so each stage samples its predecessor's pre-edge value.
  always_ff @(posedge dst_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) stage[i] <= '0;
    end else begin
      stage[0] <= ptr_gray;
      for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
    end
  end

  assign ptr_gray_sync = stage[STAGES-1];

  // Bit i of the binary value is the XOR of all Gray bits at or above i.
  always_comb begin
    bin_next = '0;
    for (int i = 0; i < PW; i++) bin_next[i] = ^(stage[STAGES-1] >> i);
  end

  assign delta_next = bin_next - ptr_bin_sync;

  always_ff @(posedge dst_clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_bin_sync <= '0;
      ptr_delta    <= '0;
      ptr_upd      <= 1'b0;
      err_jump     <= 1'b0;
      sync_valid   <= 1'b0;
      flush_cnt    <= '0;
    end else begin
      ptr_bin_sync <= bin_next;

      // Until the chain has flushed, the stages may still hold reset zeros,
      // so advances seen in that window are not reported.
      if (sync_valid) begin
        ptr_delta <= delta_next;
        ptr_upd   <= (delta_next != '0);
      end else begin
        ptr_delta <= '0;
        ptr_upd   <= 1'b0;
      end

      if (sync_valid && (delta_next > DEPTH)) err_jump <= 1'b1;
      else if (err_clr)                       err_jump <= 1'b0;

      if (!sync_valid) begin
        flush_cnt <= flush_cnt + 3'd1;
        if (flush_cnt + 3'd1 == FLUSH_LAST) sync_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Directed bench for gray_ptr_sync: three builds (STAGES = 2, 3, 4) driven
// from one stimulus stream, checked against hand-computed values.
module tb_gray_ptr_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] ptr_gray;
  logic       err_clr;

  logic [4:0] g2, b2, d2, g3, b3, d3, g4, b4, d4;
  logic       u2, e2, v2, u3, e3, v3, u4, e4, v4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  gray_ptr_sync #(.ADDR_WIDTH(4), .STAGES(2)) dut2 (
    .dst_clk(clk), .rst_n(rst_n), .ptr_gray(ptr_gray), .err_clr(err_clr),
    .ptr_gray_sync(g2), .ptr_bin_sync(b2), .ptr_delta(d2), .ptr_upd(u2),
    .err_jump(e2), .sync_valid(v2));

  gray_ptr_sync #(.ADDR_WIDTH(4), .STAGES(3)) dut3 (
    .dst_clk(clk), .rst_n(rst_n), .ptr_gray(ptr_gray), .err_clr(err_clr),
    .ptr_gray_sync(g3), .ptr_bin_sync(b3), .ptr_delta(d3), .ptr_upd(u3),
    .err_jump(e3), .sync_valid(v3));

  gray_ptr_sync #(.ADDR_WIDTH(4), .STAGES(4)) dut4 (
    .dst_clk(clk), .rst_n(rst_n), .ptr_gray(ptr_gray), .err_clr(err_clr),
    .ptr_gray_sync(g4), .ptr_bin_sync(b4), .ptr_delta(d4), .ptr_upd(u4),
    .err_jump(e4), .sync_valid(v4));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs n edges and records what the STAGES=2 build reports on its pulses.
  task automatic watch(input int n, output int pulses, output logic [4:0] dseen,
                       output logic eseen);
    pulses = 0;
    dseen  = '0;
    eseen  = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (u2) begin
        pulses++;
        dseen = d2;
        eseen = e2;
      end
    end
  endtask

  // Reset, then flush all three builds (the deepest needs 5 edges).
  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".gsync"}, 32'(g2), 0);
    check({tag, ".bin"},   32'(b2), 0);
    check({tag, ".delta"}, 32'(d2), 0);
    check({tag, ".upd"},   32'(u2), 0);
    check({tag, ".err"},   32'(e2), 0);
    check({tag, ".valid"}, 32'(v2), 0);
    check({tag, ".valid4"}, 32'(v4), 0);
    check({tag, ".err4"},  32'(e4), 0);
  endtask

  int         pulses;
  logic [4:0] dseen;
  logic       eseen;
  int         upd_seen;

  initial begin
    rst_n    = 1'b1;
    ptr_gray = '0;
    err_clr  = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    check_all_zero("reset");

    // Flush sequence after first release: valid on edge STAGES+1.
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("flush.v2.e%0d", k), 32'(v2), 32'(k >= 3));
      check($sformatf("flush.v3.e%0d", k), 32'(v3), 32'(k >= 4));
      check($sformatf("flush.v4.e%0d", k), 32'(v4), 32'(k >= 5));
    end

    // Latency: step 0 -> 1 ahead of edge 0.
    ptr_gray = 5'h01;
    for (int k = 0; k <= 6; k++) begin
      tick();
      check($sformatf("lat.g2.e%0d", k), 32'(g2), 32'(k >= 1));
      check($sformatf("lat.b2.e%0d", k), 32'(b2), 32'(k >= 2));
      check($sformatf("lat.u2.e%0d", k), 32'(u2), 32'(k == 2));
      check($sformatf("lat.d2.e%0d", k), 32'(d2), 32'(k == 2));
      check($sformatf("lat.b3.e%0d", k), 32'(b3), 32'(k >= 3));
      check($sformatf("lat.u3.e%0d", k), 32'(u3), 32'(k == 3));
      check($sformatf("lat.b4.e%0d", k), 32'(b4), 32'(k >= 4));
      check($sformatf("lat.u4.e%0d", k), 32'(u4), 32'(k == 4));
    end

    // Multi-step advance 0 -> 5 (Gray 0x07).
    ptr_gray = 5'h00;
    do_reset();
    ptr_gray = 5'h07;
    watch(7, pulses, dseen, eseen);
    check("multi.pulses", 32'(pulses), 1);
    check("multi.delta",  32'(dseen), 5);
    check("multi.bin",    32'(b2), 5);
    check("multi.delta0", 32'(d2), 0);
    check("multi.err",    32'(e2), 0);

    // Walk to 30 in legal steps, then wrap to 1: 5 -> 20 -> 30 -> 1.
    ptr_gray = 5'h1E;
    watch(7, pulses, dseen, eseen);
    check("walk.d15", 32'(dseen), 15);
    ptr_gray = 5'h11;
    watch(7, pulses, dseen, eseen);
    check("walk.d10", 32'(dseen), 10);
    check("walk.bin30", 32'(b2), 30);
    ptr_gray = 5'h01;
    watch(7, pulses, dseen, eseen);
    check("wrap.pulses", 32'(pulses), 1);
    check("wrap.delta",  32'(dseen), 3);
    check("wrap.bin",    32'(b2), 1);
    check("wrap.err",    32'(e2), 0);

    // Jump error: 0 -> 17 (Gray 0x19).
    ptr_gray = 5'h00;
    do_reset();
    ptr_gray = 5'h19;
    watch(7, pulses, dseen, eseen);
    check("jump.delta", 32'(dseen), 17);
    check("jump.err_at_pulse", 32'(eseen), 1);
    check("jump.err4", 32'(e4), 1);
    for (int i = 0; i < 10; i++) tick();
    check("jump.sticky", 32'(e2), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("jump.clr", 32'(e2), 0);
    check("jump.clr4", 32'(e4), 0);
    // 17 -> 2 (Gray 0x03) is another 17-step jump, with clear held high.
    err_clr  = 1'b1;
    ptr_gray = 5'h03;
    watch(7, pulses, dseen, eseen);
    check("jump2.delta", 32'(dseen), 17);
    check("jump2.set_wins", 32'(eseen), 1);
    check("jump2.cleared", 32'(e2), 0);
    err_clr = 1'b0;
    // 2 -> 18 (Gray 0x1B) is exactly the depth: not an error.
    ptr_gray = 5'h1B;
    watch(7, pulses, dseen, eseen);
    check("depth.delta", 32'(dseen), 16);
    check("depth.err", 32'(eseen), 0);

    // Reset mid-run with err_jump set and pointer at 12 (Gray 0x0A).
    ptr_gray = 5'h00;
    do_reset();
    ptr_gray = 5'h19;
    watch(7, pulses, dseen, eseen);
    ptr_gray = 5'h0A;
    watch(7, pulses, dseen, eseen);
    check("mid.bin12", 32'(b2), 12);
    check("mid.err_pre", 32'(e2), 1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("mid");
    tick();
    rst_n = 1'b1;
    upd_seen = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (u2 || u3 || u4) upd_seen++;
      if (k <= 5) begin
        check($sformatf("mid.v2.e%0d", k), 32'(v2), 32'(k >= 3));
        check($sformatf("mid.v4.e%0d", k), 32'(v4), 32'(k >= 5));
      end
    end
    check("mid.no_upd", 32'(upd_seen), 0);
    check("mid.bin_after", 32'(b2), 12);
    check("mid.bin4_after", 32'(b4), 12);
    check("mid.err_after", 32'(e2), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
